// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a word-addressed on-chip RAM.
// Independent write (AW/W/B) and read (AR/R) channels, one outstanding transaction each.
module axi_lite_ram_slave #(
   parameter int unsigned       ADDR_W = 32,
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       DEPTH  = 1024,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rvalid,
   input  logic              rready
);

   localparam int unsigned STRB_W      = DATA_W / 8;
   localparam int unsigned IDX_W       = $clog2(DEPTH);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   logic [DATA_W-1:0] mem_q [DEPTH];

   wstate_e           wstate_q, wstate_d;
   logic              aw_held_q, aw_held_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic              w_held_q, w_held_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              wcommit_c;

   rstate_e           rstate_q, rstate_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic              awready_c, wready_c, arready_c;

   // Address decode: in window and word aligned, offset relative to BASE
   logic [ADDR_W-1:0] waddr_off_c, raddr_off_c;
   logic              wok_c, rok_c;
   logic [IDX_W-1:0]  widx_c, ridx_c;

   always_comb begin
      waddr_off_c = awaddr_q - BASE;
      raddr_off_c = araddr - BASE;
      wok_c  = (awaddr_q >= BASE) && (waddr_off_c[ADDR_W-1:IDX_W+2] == '0) &&
               (waddr_off_c[1:0] == 2'b00);
      rok_c  = (araddr >= BASE) && (raddr_off_c[ADDR_W-1:IDX_W+2] == '0) &&
               (raddr_off_c[1:0] == 2'b00);
      widx_c = waddr_off_c[IDX_W+1:2];
      ridx_c = raddr_off_c[IDX_W+1:2];
   end

   // Readies depend only on internal state and reset
   assign awready_c = !rst && !aw_held_q && (wstate_q == W_IDLE);
   assign wready_c  = !rst && !w_held_q  && (wstate_q == W_IDLE);
   assign arready_c = !rst && (rstate_q == R_IDLE);

   assign awready = awready_c;
   assign wready  = wready_c;
   assign arready = arready_c;
   assign bvalid  = (wstate_q == W_RESP);
   assign bresp   = bresp_q;
   assign rvalid  = (rstate_q == R_DATA);
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate_q  <= W_IDLE;
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         rstate_q  <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         wstate_q  <= wstate_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         rstate_q  <= rstate_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // Write channel: collect AW and W in any order, commit, then hold B until accepted
   always_comb begin
      wstate_d  = wstate_q;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      wcommit_c = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            if (aw_held_q && w_held_q) begin
               wcommit_c = 1'b1;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               bresp_d   = wok_c ? RESP_OKAY : RESP_SLVERR;
               wstate_d  = W_RESP;
            end else begin
               if (awvalid && awready_c) begin
                  aw_held_d = 1'b1;
                  awaddr_d  = awaddr;
               end
               if (wvalid && wready_c) begin
                  w_held_d = 1'b1;
                  wdata_d  = wdata;
                  wstrb_d  = wstrb;
               end
            end
         end
         W_RESP: begin
            if (bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // RAM byte-lane writes; contents survive reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_W; i++) begin
         if (wcommit_c && wok_c && wstrb_q[i]) begin
            mem_q[widx_c][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   // Read channel: registered lookup returns pre-commit data on a same-edge write
   always_comb begin
      rstate_d = rstate_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      case (rstate_q)
         R_IDLE: begin
            if (arvalid && arready_c) begin
               rstate_d = R_DATA;
               rdata_d  = rok_c ? mem_q[ridx_c] : '0;
               rresp_d  = rok_c ? RESP_OKAY : RESP_SLVERR;
            end
         end
         R_DATA: begin
            if (rready) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

endmodule
